rpn_op_sequencer: RTL
=====================

Name: rpn_op_sequencer

Overview:
- Parametrised successor to the RPN operator controller.
- Takes an operator request from the token decoder and checks the operand stack has enough entries.
- Pops the operands with a pop handshake, then runs a multi-cycle ALU via a start/done handshake.
- Pushes the result back onto the stack, then reports completion (ans_ready) or an error to the UART response path.

Parameters:
- DATA_W, 32, operand/result width in bits
- MAX_ARGS, 2, maximum operator arity supported (>=1)
- ARG_W, 2, width of arity/pop count; must satisfy 2**ARG_W > MAX_ARGS
- DEPTH_W, 5, width of stack occupancy input
- OP_W, 4, opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operator request
- op_ready  out  1  high only in IDLE; request accepted when op_valid&&op_ready
- op_code  in  OP_W  opcode, sampled on accept
- arg_cnt  in  ARG_W  operator arity, sampled on accept
- stack_depth  in  DEPTH_W  current stack occupancy, sampled on accept
- pop_req  out  1  pop request, held until pop_ack
- pop_ack  in  1  pop completes this cycle; pop_data valid
- pop_data  in  DATA_W  popped value
- alu_start  out  1  one-cycle start pulse
- alu_op  out  OP_W  latched opcode, stable from start until done
- alu_operands  out  MAX_ARGS*DATA_W  operand i in slice i; slice 0 = deepest operand
- alu_done  in  1  ALU result valid; never in the same cycle as alu_start
- alu_result  in  DATA_W  ALU result
- alu_err  in  1  ALU fault (e.g. divide by zero), qualified by alu_done
- push_req  out  1  push request, held until push_ack
- push_data  out  DATA_W  latched result
- push_ack  in  1  push completes
- pop_cnt  out  ARG_W  operands popped for the current operator
- ans_ready  out  1  one-cycle pulse: result pushed
- err  out  1  one-cycle pulse: operator aborted
- err_code  out  2  0=none, 1=stack underflow, 2=bad arity, 3=ALU fault; held until next accept

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - op_ready=1 after reset.
  - pop_req, alu_start, push_req, ans_ready, err = 0.
  - pop_cnt=0, err_code=0, alu_op=0, alu_operands=0, push_data=0.
- Reset mid-operation aborts immediately.
  - No push or ans_ready follows.
  - Already-popped operands are lost (stack owner's concern).
- FSM states: IDLE, POP, EXEC, WAIT, PUSH, DONE, FAIL.
- IDLE, on accept:
  - Latch op_code and arity; clear pop_cnt and err_code.
  - arg_cnt > MAX_ARGS: FAIL, err_code=2.
  - else stack_depth < arg_cnt: FAIL, err_code=1.
  - else arg_cnt == 0: EXEC.
  - else: POP.
- POP:
  - pop_req=1 every cycle in POP.
  - Each cycle with pop_ack: store pop_data into slice (arity-1-pop_cnt), then pop_cnt++.
  - The first pop is the top of stack and lands in the highest used slice.
  - When the incremented pop_cnt equals arity: EXEC (pop_req drops next cycle).
- EXEC: alu_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - alu_done&&!alu_err: latch alu_result into push_data, go to PUSH.
  - alu_done&&alu_err: FAIL, err_code=3.
  - No timeout.
- PUSH: push_req=1 until push_ack, then DONE.
- DONE: ans_ready=1 for one cycle, then IDLE.
- FAIL: err=1 for one cycle, then IDLE. No push in FAIL.
- pop_cnt holds its final value until the next accept.
- op_valid outside IDLE is ignored (op_ready=0); no queuing.
- Unused operand slices (index >= arity) are driven 0.
- Latency, arity 2 with zero-wait acks and alu_done one cycle after start:
  - Accept at cycle T.
  - pops at T+1, T+2; alu_start T+3; done T+4; push T+5; ans_ready T+6.
  - Back in IDLE at T+7.
- Boundaries:
  - stack_depth == arg_cnt is legal.
  - stack_depth is sampled once at accept; later changes are ignored.
  - pop_ack and push_ack are only meaningful while the matching req is high; otherwise ignored.

Decomposition:
- Shared package rpn_pkg:
  - FSM state enum.
  - err_code constants (ERR_NONE, ERR_UNDERFLOW, ERR_ARITY, ERR_ALU).
  - Opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) shared with the ALU and token decoder.
- One natural sub-module: rpn_operand_buffer.
  - MAX_ARGS x DATA_W register file.
  - Indexed write, clear on accept, flat read bus.
  - The FSM stays in the top module.

Test Plan:
- Add, arity 2, depth 3, pops return 7 then 5, ALU returns 12 one cycle after start, immediate acks:
  - alu_operands = {slice1=7, slice0=5}.
  - pop_cnt=2; push_data=12; ans_ready pulse exactly at T+6; op_ready high at T+7.
- Underflow, arity 2, depth 1:
  - err pulse at T+1, err_code=1.
  - pop_req never asserted, no push, pop_cnt=0.
- Arity 3 with MAX_ARGS=2: err_code=2, no pops.
- Div with alu_done&&alu_err (operands 9, 0): err pulse, err_code=3, push_req never high, ans_ready never high.
- Backpressure: pop_ack delayed 3 cycles per pop, push_ack delayed 4 cycles, ALU takes 5 cycles:
  - pop_req/push_req held steady throughout.
  - alu_start exactly one cycle.
  - op_valid pulses during busy are ignored.
  - ans_ready fires once.
- Reset mid-WAIT (rst_n low for 2 cycles):
  - All outputs go to reset values asynchronously, op_ready=1.
  - A later alu_done is ignored.
  - A new add then completes normally.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator datapath: sequencer states,
// error codes and the opcode map shared with the ALU and token decoder.
package rpn_pkg;

    typedef logic [2:0] rpn_state_t;

    localparam rpn_state_t ST_IDLE = 3'd0;
    localparam rpn_state_t ST_POP  = 3'd1;
    localparam rpn_state_t ST_EXEC = 3'd2;
    localparam rpn_state_t ST_WAIT = 3'd3;
    localparam rpn_state_t ST_PUSH = 3'd4;
    localparam rpn_state_t ST_DONE = 3'd5;
    localparam rpn_state_t ST_FAIL = 3'd6;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_ARITY     = 2'd2;
    localparam logic [1:0] ERR_ALU       = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

endpackage

// File: rtl/rpn_operand_buffer.sv
// Operand register file: one DATA_W slot per possible argument, indexed
// write from the pop path, cleared on every accepted operator.
module rpn_operand_buffer #(
    parameter int DATA_W   = 32,
    parameter int MAX_ARGS = 2,
    parameter int ARG_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [ARG_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [MAX_ARGS*DATA_W-1:0] rd_bus
);

    for (genvar gi = 0; gi < MAX_ARGS; gi++) begin : g_slot
        logic [DATA_W-1:0] slot_r;

        // Slot storage: clear on accept so unused slices read as zero
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_r <= {DATA_W{1'b0}};
            end else if (clr) begin
                slot_r <= {DATA_W{1'b0}};
            end else if (wr_en && (wr_idx == ARG_W'(gi))) begin
                slot_r <= wr_data;
            end else begin
                slot_r <= slot_r;
            end
        end

        assign rd_bus[gi*DATA_W +: DATA_W] = slot_r;
    end

endmodule

// File: rtl/rpn_op_sequencer.sv
// RPN operator sequencer: checks arity/stack depth, pops operands, runs the
// multi-cycle ALU, pushes the result and reports completion or an error.
module rpn_op_sequencer
    import rpn_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_ARGS = 2,
    parameter int ARG_W    = 2,
    parameter int DEPTH_W  = 5,
    parameter int OP_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [OP_W-1:0]            op_code,
    input  logic [ARG_W-1:0]           arg_cnt,
    input  logic [DEPTH_W-1:0]         stack_depth,
    output logic                       pop_req,
    input  logic                       pop_ack,
    input  logic [DATA_W-1:0]          pop_data,
    output logic                       alu_start,
    output logic [OP_W-1:0]            alu_op,
    output logic [MAX_ARGS*DATA_W-1:0] alu_operands,
    input  logic                       alu_done,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_err,
    output logic                       push_req,
    output logic [DATA_W-1:0]          push_data,
    input  logic                       push_ack,
    output logic [ARG_W-1:0]           pop_cnt,
    output logic                       ans_ready,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int CMP_W = (DEPTH_W > ARG_W) ? DEPTH_W : ARG_W;

    rpn_state_t          state_r;
    rpn_state_t          state_n_s;
    logic                accept_s;
    logic                err_wr_s;
    logic [1:0]          err_val_s;
    logic                pop_fire_s;
    logic                alu_ok_s;
    logic [ARG_W-1:0]    wr_idx_s;
    logic [ARG_W-1:0]    arity_r;
    logic [ARG_W-1:0]    pop_cnt_r;
    logic [OP_W-1:0]     alu_op_r;
    logic [DATA_W-1:0]   push_data_r;
    logic [1:0]          err_code_r;
    logic                op_ready_r;
    logic                pop_req_r;
    logic                alu_start_r;
    logic                push_req_r;
    logic                ans_ready_r;
    logic                err_r;

    // First pop is top of stack and lands in the highest used slice
    assign wr_idx_s = arity_r - pop_cnt_r - ARG_W'(1);

    // Next-state and datapath strobes
    always_comb begin
        state_n_s  = state_r;
        accept_s   = 1'b0;
        err_wr_s   = 1'b0;
        err_val_s  = ERR_NONE;
        pop_fire_s = 1'b0;
        alu_ok_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid && op_ready_r) begin
                    accept_s = 1'b1;
                    err_wr_s = 1'b1;
                    if (arg_cnt > ARG_W'(MAX_ARGS)) begin
                        state_n_s = ST_FAIL;
                        err_val_s = ERR_ARITY;
                    end else if (CMP_W'(stack_depth) < CMP_W'(arg_cnt)) begin
                        state_n_s = ST_FAIL;
                        err_val_s = ERR_UNDERFLOW;
                    end else if (arg_cnt == {ARG_W{1'b0}}) begin
                        state_n_s = ST_EXEC;
                    end else begin
                        state_n_s = ST_POP;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_POP: begin
                if (pop_ack) begin
                    pop_fire_s = 1'b1;
                    if ((pop_cnt_r + ARG_W'(1)) == arity_r) begin
                        state_n_s = ST_EXEC;
                    end else begin
                        state_n_s = ST_POP;
                    end
                end else begin
                    state_n_s = ST_POP;
                end
            end
            ST_EXEC: state_n_s = ST_WAIT;
            ST_WAIT: begin
                if (alu_done && alu_err) begin
                    state_n_s = ST_FAIL;
                    err_wr_s  = 1'b1;
                    err_val_s = ERR_ALU;
                end else if (alu_done) begin
                    state_n_s = ST_PUSH;
                    alu_ok_s  = 1'b1;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_PUSH: begin
                if (push_ack) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_PUSH;
                end
            end
            ST_DONE: state_n_s = ST_IDLE;
            ST_FAIL: state_n_s = ST_IDLE;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register and Moore-style handshake outputs, registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_ready_r  <= 1'b1;
            pop_req_r   <= 1'b0;
            alu_start_r <= 1'b0;
            push_req_r  <= 1'b0;
            ans_ready_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            op_ready_r  <= (state_n_s == ST_IDLE);
            pop_req_r   <= (state_n_s == ST_POP);
            alu_start_r <= (state_n_s == ST_EXEC);
            push_req_r  <= (state_n_s == ST_PUSH);
            ans_ready_r <= (state_n_s == ST_DONE);
            err_r       <= (state_n_s == ST_FAIL);
        end
    end

    // Per-operator context: opcode, arity, pop count, error code, result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_r    <= {OP_W{1'b0}};
            arity_r     <= {ARG_W{1'b0}};
            pop_cnt_r   <= {ARG_W{1'b0}};
            err_code_r  <= ERR_NONE;
            push_data_r <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                alu_op_r  <= op_code;
                arity_r   <= arg_cnt;
                pop_cnt_r <= {ARG_W{1'b0}};
            end else if (pop_fire_s) begin
                pop_cnt_r <= pop_cnt_r + ARG_W'(1);
            end else begin
                pop_cnt_r <= pop_cnt_r;
            end
            if (err_wr_s) begin
                err_code_r <= err_val_s;
            end else begin
                err_code_r <= err_code_r;
            end
            if (alu_ok_s) begin
                push_data_r <= alu_result;
            end else begin
                push_data_r <= push_data_r;
            end
        end
    end

    rpn_operand_buffer #(
        .DATA_W   (DATA_W),
        .MAX_ARGS (MAX_ARGS),
        .ARG_W    (ARG_W)
    ) u_operand_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept_s),
        .wr_en   (pop_fire_s),
        .wr_idx  (wr_idx_s),
        .wr_data (pop_data),
        .rd_bus  (alu_operands)
    );

    assign op_ready  = op_ready_r;
    assign pop_req   = pop_req_r;
    assign alu_start = alu_start_r;
    assign alu_op    = alu_op_r;
    assign push_req  = push_req_r;
    assign push_data = push_data_r;
    assign pop_cnt   = pop_cnt_r;
    assign ans_ready = ans_ready_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule
